video_timing_gen_v2: RTL and testbench
======================================

Name: video_timing_gen_v2

Overview:
Second-generation raster timing generator for the DSI/VGA video path. It adds several features to the fixed-timing generator:
- timing programmable at run time, double-buffered so changes land only at a frame boundary
- 1/2/4 pixels per clock
- selectable sync polarity
- enable/graceful-stop control
- start-of-frame and end-of-line markers
It drives pattern generators and the DSI packetiser.

Parameters:
PPC, 1, pixels per clock (legal 1, 2, 4)
HW, 14, horizontal counter / out_x width
VW, 12, vertical counter / out_y width
DEF_HS, 96, reset value of shadow h_sync (clocks)
DEF_HBP, 48, reset value of shadow h_bp (clocks)
DEF_HACT, 640, reset value of shadow h_active (clocks, = pixels/PPC)
DEF_HFP, 16, reset value of shadow h_fp (clocks)
DEF_VS, 2, reset value of shadow v_sync (lines)
DEF_VBP, 33, reset value of shadow v_bp (lines)
DEF_VACT, 480, reset value of shadow v_active (lines)
DEF_VFP, 10, reset value of shadow v_fp (lines)
DEF_HPOL, 0, reset hsync polarity (1 = active-high)
DEF_VPOL, 0, reset vsync polarity

Ports:
in_pclk  input  1  pixel clock; all logic on rising edge
in_rst  input  1  asynchronous, active-high reset
in_enable  input  1  run request (level)
in_cfg_update  input  1  one-cycle pulse: capture all in_h_*/in_v_*/in_*_pol into staging
in_h_sync, in_h_bp, in_h_active, in_h_fp  input  HW each  horizontal timing (clocks)
in_v_sync, in_v_bp, in_v_active, in_v_fp  input  VW each  vertical timing (lines)
in_hs_pol, in_vs_pol  input  1 each  sync polarity (1 = active-high)
out_busy  output  1  state != IDLE
out_cfg_pending  output  1  staging holds values not yet applied
out_x  output  HW  pixel index of first pixel in current beat
out_y  output  VW  active line index
out_de  output  1  active video
out_hs  output  1  hsync, polarity applied
out_vs  output  1  vsync, polarity applied
out_sof  output  1  one-cycle pulse on the first active beat of a frame
out_eol  output  1  one-cycle pulse on the last active beat of each line

Behaviour:
Reset (async, in_rst=1):
- state=IDLE; counters h=0, v=0; staging and shadow = DEF_*; pending=0.
- Outputs: out_de=0, out_sof=0, out_eol=0, out_x=0, out_y=0, out_busy=0, out_cfg_pending=0.
- out_hs=~DEF_HPOL, out_vs=~DEF_VPOL.

Derived values, from shadow:
- HT = hs+hbp+hact+hfp; VT = vs+vbp+vact+vfp.
- Line order is sync, back porch, active, front porch; frame order likewise in lines.

Legality and counter widths:
- Legal config: sync>=1, active>=1; porches may be 0.
- HT must fit in HW bits; VT in VW bits.
- Illegal values produce undefined timing but must not lock up. The counters always wrap at HT-1/VT-1 using == compare, with a >= guard.

Frame boundary: the cycle with h==HT-1 and v==VT-1 (FB).

State machine:
- IDLE: counters held at 0; de/sof/eol=0; syncs inactive. If in_enable=1 → RUN next cycle. On the transition cycle, shadow<=staging if pending, and pending clears. The first RUN cycle has h=0, v=0.
- RUN: h increments each cycle and wraps to 0 at HT-1. v increments on h wrap and wraps at VT-1. If in_enable=0 → DRAIN.
- DRAIN: counts as RUN. At FB → IDLE. If in_enable returns to 1 before FB → RUN, with no timing discontinuity.
- Shadow load: in RUN/DRAIN, at FB, shadow<=staging if pending. The new timing applies from the next cycle (h=0, v=0).

Config staging:
- in_cfg_update captures inputs into staging and sets pending.
- A second update before FB overwrites staging; the latest values win.
- An update on the FB cycle itself is captured into staging but applied at the following FB. That cycle's load uses the prior staging content only if pending was already set; pending remains 1.

Output pipeline (all outputs registered, 1 cycle after the counter state):
- hs_act = h < hs; vs_act = v < vs.
- out_hs = hs_act ^ ~hpol; out_vs = vs_act ^ ~vpol.
- de = (hs+hbp <= h < hs+hbp+hact) && (vs+vbp <= v < vs+vbp+vact).
- out_x = (h-(hs+hbp))*PPC when de, else 0. The multiply is a shift; the result is truncated to HW.
- out_y = v-(vs+vbp) when de, else 0.
- out_sof = de at the first active h of the first active v.
- out_eol = de at h = hs+hbp+hact-1.
- Polarity bits come from the shadow, so a polarity change also lands only at FB.

Reset mid-frame: immediate return to the reset values above. The next in_enable starts a fresh frame at h=0, v=0 using the DEF_* timing.

Test Plan:
- Defaults, PPC=1, enable held: period 800*525=420000 cycles between out_sof pulses. Per frame, 307200 de cycles and 480 out_eol pulses. First de at h=144, v=35 (output cycle +1). hs low for 96 clocks; vs low for 2 lines.
- PPC=4, in_h_active=160, others default, update before enable: out_x sequence 0,4,...,636 per line. HT=320; de 160 clocks/line.
- in_cfg_update mid-frame with h_active=320: out_cfg_pending=1 until FB. The current frame still has 640 de/line; the next frame has 320 de/line, and pending drops.
- Drop in_enable mid-frame (v=100): the frame completes; out_busy falls after FB with syncs inactive. Re-raise in_enable during DRAIN: no gap, sof period unchanged.
- in_hs_pol=1, in_vs_pol=1 via update: after FB, hs is high for 96 clocks and vs high for 2 lines. Before FB, polarity is unchanged.
- Assert in_rst at v=200 while pending=1: all outputs go to reset values asynchronously and pending clears. On restart, timing equals the defaults.

Source files
------------

// File: rtl/video_timing_gen_v2_if.sv
// Bus bundle for the second-generation raster timing generator.
// The pattern source / control side holds the master modport; the
// timing generator holds the slave modport.
//   in_enable        run request (level)
//   in_cfg_update    one-cycle pulse that captures all timing inputs into staging
//   in_h_*           horizontal sync / back porch / active / front porch (clocks)
//   in_v_*           vertical sync / back porch / active / front porch (lines)
//   in_hs_pol        hsync polarity (1 = active-high)
//   in_vs_pol        vsync polarity (1 = active-high)
//   out_busy         generator not idle
//   out_cfg_pending  staged timing not yet applied
//   out_x, out_y     first pixel index of the beat, active line index
//   out_de, out_hs, out_vs, out_sof, out_eol  raster strobes
interface video_timing_gen_v2_if #(
    parameter int HW = 14,
    parameter int VW = 12
) ();
    logic          in_enable;
    logic          in_cfg_update;
    logic [HW-1:0] in_h_sync;
    logic [HW-1:0] in_h_bp;
    logic [HW-1:0] in_h_active;
    logic [HW-1:0] in_h_fp;
    logic [VW-1:0] in_v_sync;
    logic [VW-1:0] in_v_bp;
    logic [VW-1:0] in_v_active;
    logic [VW-1:0] in_v_fp;
    logic          in_hs_pol;
    logic          in_vs_pol;
    logic          out_busy;
    logic          out_cfg_pending;
    logic [HW-1:0] out_x;
    logic [VW-1:0] out_y;
    logic          out_de;
    logic          out_hs;
    logic          out_vs;
    logic          out_sof;
    logic          out_eol;

    modport master (
        output in_enable, in_cfg_update,
        output in_h_sync, in_h_bp, in_h_active, in_h_fp,
        output in_v_sync, in_v_bp, in_v_active, in_v_fp,
        output in_hs_pol, in_vs_pol,
        input  out_busy, out_cfg_pending, out_x, out_y,
        input  out_de, out_hs, out_vs, out_sof, out_eol
    );

    modport slave (
        input  in_enable, in_cfg_update,
        input  in_h_sync, in_h_bp, in_h_active, in_h_fp,
        input  in_v_sync, in_v_bp, in_v_active, in_v_fp,
        input  in_hs_pol, in_vs_pol,
        output out_busy, out_cfg_pending, out_x, out_y,
        output out_de, out_hs, out_vs, out_sof, out_eol
    );
endinterface

// File: rtl/video_timing_gen_v2.sv
// Programmable raster timing generator, 1/2/4 pixels per clock.
// Timing is written into a staging copy by in_cfg_update and moved into the
// active (shadow) copy only when a frame starts, so a frame never mixes two
// timings. Dropping in_enable lets the current frame finish before idling.
// Ports:
//   in_pclk  pixel clock, rising edge
//   in_rst   asynchronous active-high reset
//   bus      video_timing_gen_v2_if.slave (config inputs, raster outputs)
module video_timing_gen_v2 #(
    parameter int PPC      = 1,
    parameter int HW       = 14,
    parameter int VW       = 12,
    parameter int DEF_HS   = 96,
    parameter int DEF_HBP  = 48,
    parameter int DEF_HACT = 640,
    parameter int DEF_HFP  = 16,
    parameter int DEF_VS   = 2,
    parameter int DEF_VBP  = 33,
    parameter int DEF_VACT = 480,
    parameter int DEF_VFP  = 10,
    parameter int DEF_HPOL = 0,
    parameter int DEF_VPOL = 0
) (
    input logic                  in_pclk,
    input logic                  in_rst,
    video_timing_gen_v2_if.slave bus
);
    localparam int   PPC_SH     = (PPC >= 4) ? 2 : ((PPC >= 2) ? 1 : 0);
    localparam logic DEF_HPOL_B = (DEF_HPOL != 0);
    localparam logic DEF_VPOL_B = (DEF_VPOL != 0);

    typedef struct packed {
        logic [HW-1:0] hs;
        logic [HW-1:0] hbp;
        logic [HW-1:0] hact;
        logic [HW-1:0] hfp;
        logic [VW-1:0] vs;
        logic [VW-1:0] vbp;
        logic [VW-1:0] vact;
        logic [VW-1:0] vfp;
        logic          hpol;
        logic          vpol;
    } cfg_t;

    localparam cfg_t DEF_CFG = '{
        hs:   HW'(DEF_HS),   hbp:  HW'(DEF_HBP),
        hact: HW'(DEF_HACT), hfp:  HW'(DEF_HFP),
        vs:   VW'(DEF_VS),   vbp:  VW'(DEF_VBP),
        vact: VW'(DEF_VACT), vfp:  VW'(DEF_VFP),
        hpol: DEF_HPOL_B,    vpol: DEF_VPOL_B
    };

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t        state_p0;
    logic [HW-1:0] h_p0;
    logic [VW-1:0] v_p0;
    cfg_t          stg_p0;
    cfg_t          shd_p0;
    logic          pending_p0;

    cfg_t          cfg_in;
    logic [HW-1:0] h_start, h_end, ht_m1, h_nxt;
    logic [VW-1:0] v_start, v_end, vt_m1, v_nxt;
    logic          h_wrap, v_wrap, fb, load, running, de_c;

    always_comb begin
        cfg_in      = DEF_CFG;
        cfg_in.hs   = bus.in_h_sync;
        cfg_in.hbp  = bus.in_h_bp;
        cfg_in.hact = bus.in_h_active;
        cfg_in.hfp  = bus.in_h_fp;
        cfg_in.vs   = bus.in_v_sync;
        cfg_in.vbp  = bus.in_v_bp;
        cfg_in.vact = bus.in_v_active;
        cfg_in.vfp  = bus.in_v_fp;
        cfg_in.hpol = bus.in_hs_pol;
        cfg_in.vpol = bus.in_vs_pol;
    end

    assign h_start = shd_p0.hs + shd_p0.hbp;
    assign h_end   = h_start + shd_p0.hact;
    assign ht_m1   = h_end + shd_p0.hfp - HW'(1);
    assign v_start = shd_p0.vs + shd_p0.vbp;
    assign v_end   = v_start + shd_p0.vact;
    assign vt_m1   = v_end + shd_p0.vfp - VW'(1);

    // >= rather than == so an illegal (or just-shrunk) timing still wraps
    assign h_wrap  = (h_p0 >= ht_m1);
    assign v_wrap  = (v_p0 >= vt_m1);
    assign fb      = h_wrap && v_wrap;
    assign h_nxt   = h_wrap ? '0 : h_p0 + HW'(1);
    assign v_nxt   = h_wrap ? (v_wrap ? '0 : v_p0 + VW'(1)) : v_p0;

    // Staging moves to shadow on the idle->run step or at a frame boundary
    assign load    = pending_p0 && ((state_p0 == IDLE) ? bus.in_enable : fb);

    // Stage 0: control state, raster counters, staging and shadow timing
    always_ff @(posedge in_pclk or posedge in_rst) begin
        if (in_rst) begin
            state_p0   <= IDLE;
            h_p0       <= '0;
            v_p0       <= '0;
            stg_p0     <= DEF_CFG;
            shd_p0     <= DEF_CFG;
            pending_p0 <= 1'b0;
        end else begin
            if (bus.in_cfg_update) begin
                stg_p0 <= cfg_in;
            end
            if (load) begin
                shd_p0 <= stg_p0;
            end
            // An update landing on the load cycle keeps pending set for the next boundary
            pending_p0 <= bus.in_cfg_update || (pending_p0 && !load);
            case (state_p0)
                IDLE: begin
                    h_p0 <= '0;
                    v_p0 <= '0;
                    if (bus.in_enable) begin
                        state_p0 <= RUN;
                    end
                end
                RUN: begin
                    h_p0 <= h_nxt;
                    v_p0 <= v_nxt;
                    if (!bus.in_enable) begin
                        state_p0 <= DRAIN;
                    end
                end
                DRAIN: begin
                    h_p0 <= h_nxt;
                    v_p0 <= v_nxt;
                    if (fb) begin
                        state_p0 <= IDLE;
                    end else if (bus.in_enable) begin
                        state_p0 <= RUN;
                    end
                end
                default: begin
                    state_p0 <= IDLE;
                end
            endcase
        end
    end

    assign running = (state_p0 != IDLE);
    assign de_c    = running &&
                     (h_p0 >= h_start) && (h_p0 < h_end) &&
                     (v_p0 >= v_start) && (v_p0 < v_end);

    logic          vld_p1, hs_p1, vs_p1, sof_p1, eol_p1;
    logic [HW-1:0] x_p1;
    logic [VW-1:0] y_p1;

    // Stage 1: registered raster outputs derived from the stage-0 counters
    always_ff @(posedge in_pclk or posedge in_rst) begin
        if (in_rst) begin
            vld_p1 <= 1'b0;
            x_p1   <= '0;
            y_p1   <= '0;
            sof_p1 <= 1'b0;
            eol_p1 <= 1'b0;
            hs_p1  <= ~DEF_HPOL_B;
            vs_p1  <= ~DEF_VPOL_B;
        end else begin
            vld_p1 <= de_c;
            x_p1   <= de_c ? ((h_p0 - h_start) << PPC_SH) : '0;
            y_p1   <= de_c ? (v_p0 - v_start) : '0;
            sof_p1 <= de_c && (h_p0 == h_start) && (v_p0 == v_start);
            eol_p1 <= de_c && (h_p0 == h_end - HW'(1));
            hs_p1  <= (running && (h_p0 < shd_p0.hs)) ^ ~shd_p0.hpol;
            vs_p1  <= (running && (v_p0 < shd_p0.vs)) ^ ~shd_p0.vpol;
        end
    end

    assign bus.out_busy        = running;
    assign bus.out_cfg_pending = pending_p0;
    assign bus.out_de          = vld_p1;
    assign bus.out_x           = x_p1;
    assign bus.out_y           = y_p1;
    assign bus.out_sof         = sof_p1;
    assign bus.out_eol         = eol_p1;
    assign bus.out_hs          = hs_p1;
    assign bus.out_vs          = vs_p1;
endmodule

// File: tb/tb_video_timing_gen_v2.sv
// Testbench for video_timing_gen_v2: small default timing so whole frames
// are short, a table of timings with hand-derived per-frame figures, a few
// corner sequences, and randomized traffic checked every cycle against a
// frame-position reference model.
module tb_video_timing_gen_v2;
    localparam int PPC = 2;
    localparam int HW  = 10;
    localparam int VW  = 8;
    localparam int D_HS = 3, D_HBP = 2, D_HACT = 6, D_HFP = 2;
    localparam int D_VS = 2, D_VBP = 2, D_VACT = 3, D_VFP = 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    video_timing_gen_v2_if #(.HW(HW), .VW(VW)) vif ();

    video_timing_gen_v2 #(
        .PPC(PPC), .HW(HW), .VW(VW),
        .DEF_HS(D_HS), .DEF_HBP(D_HBP), .DEF_HACT(D_HACT), .DEF_HFP(D_HFP),
        .DEF_VS(D_VS), .DEF_VBP(D_VBP), .DEF_VACT(D_VACT), .DEF_VFP(D_VFP),
        .DEF_HPOL(0), .DEF_VPOL(0)
    ) dut (
        .in_pclk(clk),
        .in_rst(rst),
        .bus(vif)
    );

    typedef struct {
        int hs, hbp, hact, hfp, vs, vbp, vact, vfp;
        bit hpol, vpol;
    } tcfg_t;

    typedef struct {
        tcfg_t cfg;
        int    period, de_cnt, eol_cnt, last_x, hs_act, vs_act;
    } vec_t;

    int n_assert = 0;
    int n_fail   = 0;
    int cyc      = 0;

    // Reference model: position within the frame plus run/stop flags
    tcfg_t m_shd, m_stg;
    bit    m_pend, m_act, m_stop;
    int    m_p;
    bit    e_busy, e_pend, e_de, e_hs, e_vs, e_sof, e_eol;
    int    e_x, e_y;

    function automatic tcfg_t def_cfg();
        tcfg_t c;
        c.hs = D_HS; c.hbp = D_HBP; c.hact = D_HACT; c.hfp = D_HFP;
        c.vs = D_VS; c.vbp = D_VBP; c.vact = D_VACT; c.vfp = D_VFP;
        c.hpol = 1'b0; c.vpol = 1'b0;
        return c;
    endfunction

    function automatic tcfg_t mk(int hs, int hbp, int hact, int hfp,
                                 int vs, int vbp, int vact, int vfp, bit hp, bit vp);
        tcfg_t c;
        c.hs = hs; c.hbp = hbp; c.hact = hact; c.hfp = hfp;
        c.vs = vs; c.vbp = vbp; c.vact = vact; c.vfp = vfp;
        c.hpol = hp; c.vpol = vp;
        return c;
    endfunction

    function automatic tcfg_t rand_cfg();
        return mk($urandom_range(1, 4), $urandom_range(0, 3), $urandom_range(1, 8),
                  $urandom_range(0, 3), $urandom_range(1, 3), $urandom_range(0, 2),
                  $urandom_range(1, 4), $urandom_range(0, 2),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    endfunction

    function automatic tcfg_t read_inputs();
        return mk(int'(vif.in_h_sync), int'(vif.in_h_bp), int'(vif.in_h_active),
                  int'(vif.in_h_fp), int'(vif.in_v_sync), int'(vif.in_v_bp),
                  int'(vif.in_v_active), int'(vif.in_v_fp), vif.in_hs_pol, vif.in_vs_pol);
    endfunction

    task automatic model_reset();
        m_shd = def_cfg(); m_stg = def_cfg();
        m_pend = 1'b0; m_act = 1'b0; m_stop = 1'b0; m_p = 0;
        e_busy = 1'b0; e_pend = 1'b0; e_de = 1'b0; e_sof = 1'b0; e_eol = 1'b0;
        e_x = 0; e_y = 0; e_hs = 1'b1; e_vs = 1'b1;
    endtask

    // Predict what the next clock edge produces, then advance the model
    task automatic model_step();
        int ht, vt, h, v, h0, v0;
        bit en, upd, fb, load;
        tcfg_t c;
        c  = m_shd;
        ht = c.hs + c.hbp + c.hact + c.hfp;
        vt = c.vs + c.vbp + c.vact + c.vfp;
        h  = m_p % ht;
        v  = m_p / ht;
        h0 = c.hs + c.hbp;
        v0 = c.vs + c.vbp;
        e_de  = m_act && h >= h0 && h < h0 + c.hact && v >= v0 && v < v0 + c.vact;
        e_x   = e_de ? (h - h0) * PPC : 0;
        e_y   = e_de ? (v - v0) : 0;
        e_sof = e_de && h == h0 && v == v0;
        e_eol = e_de && h == h0 + c.hact - 1;
        e_hs  = (m_act && h < c.hs) ? c.hpol : !c.hpol;
        e_vs  = (m_act && v < c.vs) ? c.vpol : !c.vpol;
        en    = vif.in_enable;
        upd   = vif.in_cfg_update;
        fb    = m_act && (m_p == ht * vt - 1);
        load  = m_pend && (fb || (!m_act && en));
        if (load) m_shd = m_stg;
        if (upd)  m_stg = read_inputs();
        m_pend = upd || (m_pend && !load);
        if (!m_act) begin
            m_p = 0;
            if (en) begin m_act = 1'b1; m_stop = 1'b0; end
        end else begin
            m_p = fb ? 0 : m_p + 1;
            if (!m_stop) m_stop = !en;
            else if (fb) begin m_act = 1'b0; m_stop = 1'b0; end
            else if (en) m_stop = 1'b0;
        end
        e_busy = m_act;
        e_pend = m_pend;
    endtask

    task automatic check(input string name, input int got, input int exp);
        n_assert++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    task automatic check_model();
        logic [6+HW+VW:0] got, exp;
        got = {vif.out_busy, vif.out_cfg_pending, vif.out_de, vif.out_hs, vif.out_vs,
               vif.out_sof, vif.out_eol, vif.out_x, vif.out_y};
        exp = {e_busy, e_pend, e_de, e_hs, e_vs, e_sof, e_eol, HW'(e_x), VW'(e_y)};
        n_assert++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL cycle_model cycle %0d: busy,pend,de,hs,vs,sof,eol,x,y got %b %b %b %b %b %b %b %0d %0d expected %b %b %b %b %b %b %b %0d %0d",
                     cyc, got[6+HW+VW], got[5+HW+VW], got[4+HW+VW], got[3+HW+VW], got[2+HW+VW],
                     got[1+HW+VW], got[HW+VW], vif.out_x, vif.out_y,
                     e_busy, e_pend, e_de, e_hs, e_vs, e_sof, e_eol, e_x, e_y);
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        cyc++;
        check_model();
    endtask

    task automatic drive_cfg(input tcfg_t c);
        vif.in_h_sync   = HW'(c.hs);   vif.in_h_bp     = HW'(c.hbp);
        vif.in_h_active = HW'(c.hact); vif.in_h_fp     = HW'(c.hfp);
        vif.in_v_sync   = VW'(c.vs);   vif.in_v_bp     = VW'(c.vbp);
        vif.in_v_active = VW'(c.vact); vif.in_v_fp     = VW'(c.vfp);
        vif.in_hs_pol   = c.hpol;      vif.in_vs_pol   = c.vpol;
    endtask

    task automatic apply_cfg(input tcfg_t c);
        drive_cfg(c);
        vif.in_cfg_update = 1'b1;
        tick();
        vif.in_cfg_update = 1'b0;
    endtask

    // Reset lands mid-cycle so its effect is visible before any clock edge
    task automatic do_reset();
        #2;
        rst = 1'b1;
        model_reset();
        #1;
        check_model();
        @(posedge clk);
        #1;
        rst = 1'b0;
        cyc++;
        check_model();
    endtask

    task automatic reset_checks(input string tag);
        check({tag, "_busy"}, int'(vif.out_busy), 0);
        check({tag, "_pending"}, int'(vif.out_cfg_pending), 0);
        check({tag, "_de"}, int'(vif.out_de), 0);
        check({tag, "_x"}, int'(vif.out_x), 0);
        check({tag, "_y"}, int'(vif.out_y), 0);
        check({tag, "_hs"}, int'(vif.out_hs), 1);
        check({tag, "_vs"}, int'(vif.out_vs), 1);
        check({tag, "_sof"}, int'(vif.out_sof), 0);
        check({tag, "_eol"}, int'(vif.out_eol), 0);
    endtask

    task automatic wait_sof(input string name, input int budget);
        int n;
        n = 0;
        while (!vif.out_sof && n < budget) begin tick(); n++; end
        check({name, "_sof_seen"}, int'(vif.out_sof), 1);
    endtask

    task automatic run_vec(input int i, input vec_t vv);
        int seen, t2, per, de, eol, mx, hsa, vsa, n;
        tcfg_t c;
        c = vv.cfg;
        seen = 0; t2 = 0; per = 0; de = 0; eol = 0; mx = 0; hsa = 0; vsa = 0; n = 0;
        apply_cfg(c);
        vif.in_enable = 1'b1;
        while (seen < 3 && n < 4 * vv.period + 50) begin
            tick();
            n++;
            if (vif.out_sof) begin
                seen++;
                if (seen == 2) t2 = cyc;
                if (seen == 3) per = cyc - t2;
            end
            if (seen == 2) begin
                de  += int'(vif.out_de);
                eol += int'(vif.out_eol);
                if (vif.out_de && int'(vif.out_x) > mx) mx = int'(vif.out_x);
                hsa += int'(vif.out_hs == c.hpol);
                vsa += int'(vif.out_vs == c.vpol);
            end
        end
        check($sformatf("vec%0d_sof_count", i), seen, 3);
        check($sformatf("vec%0d_period", i), per, vv.period);
        check($sformatf("vec%0d_de_per_frame", i), de, vv.de_cnt);
        check($sformatf("vec%0d_eol_per_frame", i), eol, vv.eol_cnt);
        check($sformatf("vec%0d_last_x", i), mx, vv.last_x);
        check($sformatf("vec%0d_hs_active_clocks", i), hsa, vv.hs_act);
        check($sformatf("vec%0d_vs_active_clocks", i), vsa, vv.vs_act);
        vif.in_enable = 1'b0;
        n = 0;
        while (vif.out_busy && n < 2 * vv.period + 20) begin tick(); n++; end
        check($sformatf("vec%0d_busy_after_drain", i), int'(vif.out_busy), 0);
        tick();
        check($sformatf("vec%0d_hs_idle", i), int'(vif.out_hs), int'(!c.hpol));
        check($sformatf("vec%0d_vs_idle", i), int'(vif.out_vs), int'(!c.vpol));
    endtask

    initial begin
        vec_t  vecs[4];
        int    n, t;
        int    ht, vt;
        tcfg_t nc;

        //            hs hbp hact hfp vs vbp vact vfp hp vp   period de eol lastx hs vs
        vecs[0].cfg = mk(3, 2, 6, 2, 2, 2, 3, 1, 1'b0, 1'b0);
        vecs[0].period = 104; vecs[0].de_cnt = 18; vecs[0].eol_cnt = 3;
        vecs[0].last_x = 10;  vecs[0].hs_act = 24; vecs[0].vs_act = 26;
        vecs[1].cfg = mk(1, 0, 4, 0, 1, 0, 2, 0, 1'b1, 1'b1);
        vecs[1].period = 15;  vecs[1].de_cnt = 8;  vecs[1].eol_cnt = 2;
        vecs[1].last_x = 6;   vecs[1].hs_act = 3;  vecs[1].vs_act = 5;
        vecs[2].cfg = mk(2, 3, 10, 5, 3, 1, 5, 2, 1'b1, 1'b0);
        vecs[2].period = 220; vecs[2].de_cnt = 50; vecs[2].eol_cnt = 5;
        vecs[2].last_x = 18;  vecs[2].hs_act = 22; vecs[2].vs_act = 60;
        vecs[3].cfg = mk(4, 1, 1, 3, 1, 3, 1, 4, 1'b0, 1'b1);
        vecs[3].period = 81;  vecs[3].de_cnt = 1;  vecs[3].eol_cnt = 1;
        vecs[3].last_x = 0;   vecs[3].hs_act = 36; vecs[3].vs_act = 9;

        vif.in_enable = 1'b0;
        vif.in_cfg_update = 1'b0;
        drive_cfg(def_cfg());
        model_reset();
        @(posedge clk);
        #1;
        reset_checks("por");
        rst = 1'b0;
        tick();
        tick();

        for (int i = 0; i < 4; i++) run_vec(i, vecs[i]);

        // Mid-frame update: held pending until the frame boundary
        apply_cfg(vecs[0].cfg);
        vif.in_enable = 1'b1;
        repeat (30) tick();
        apply_cfg(vecs[1].cfg);
        check("pending_mid_frame", int'(vif.out_cfg_pending), 1);
        n = 0;
        while (vif.out_cfg_pending && n < 300) begin tick(); n++; end
        check("pending_wait_cycles", n, 74);

        // Drop and re-raise enable within a frame: sof cadence unchanged
        wait_sof("drain_a", 40);
        t = cyc;
        tick(); tick();
        vif.in_enable = 1'b0;
        repeat (4) tick();
        vif.in_enable = 1'b1;
        tick();
        wait_sof("drain_b", 40);
        check("sof_period_drain_reraise", cyc - t, 15);

        // Update landing exactly on the frame-boundary cycle
        ht = 5; vt = 3;
        n = 0;
        while (!(m_act && m_p == ht * vt - 1) && n < 40) begin tick(); n++; end
        check("reached_fb_cycle", m_p, ht * vt - 1);
        apply_cfg(vecs[2].cfg);
        check("pending_after_fb_update", int'(vif.out_cfg_pending), 1);
        n = 0;
        while (vif.out_cfg_pending && n < 100) begin tick(); n++; end
        check("fb_update_defer_cycles", n, 15);
        wait_sof("fbupd_a", 300);
        t = cyc;
        tick();
        wait_sof("fbupd_b", 300);
        check("sof_period_after_fb_update", cyc - t, 220);

        // Asynchronous reset mid-frame with an update pending
        apply_cfg(vecs[3].cfg);
        repeat (50) tick();
        check("pending_before_reset", int'(vif.out_cfg_pending), 1);
        do_reset();
        reset_checks("midframe_rst");
        wait_sof("post_rst_a", 300);
        t = cyc;
        tick();
        wait_sof("post_rst_b", 300);
        check("sof_period_after_reset", cyc - t, 104);

        // Randomized traffic against the model
        for (int k = 0; k < 4000; k++) begin
            nc = rand_cfg();
            drive_cfg(nc);
            vif.in_cfg_update = ($urandom_range(0, 99) < 2);
            if (vif.in_enable) begin
                if ($urandom_range(0, 299) == 0) vif.in_enable = 1'b0;
            end else begin
                if ($urandom_range(0, 19) == 0) vif.in_enable = 1'b1;
            end
            if ($urandom_range(0, 1999) == 0) do_reset();
            else tick();
        end
        vif.in_cfg_update = 1'b0;
        vif.in_enable = 1'b0;
        n = 0;
        while (vif.out_busy && n < 400) begin tick(); n++; end
        check("final_idle", int'(vif.out_busy), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
